// File: rtl/note_recorder_pkg.sv
// Shared note-code constants for the recorder and the auto-player.
// Code bases per octave and duration class, plus the rest code.
package note_recorder_pkg;

  typedef enum logic [1:0] {
    DUR_16 = 2'd0,
    DUR_8  = 2'd1,
    DUR_4  = 2'd2
  } dur_t;

  typedef enum logic [1:0] {
    OCT_MID  = 2'd0,
    OCT_LOW  = 2'd1,
    OCT_HIGH = 2'd2
  } oct_t;

  localparam logic [5:0] REST_CODE   = 6'd0;
  localparam logic [5:0] BASE_MID_8  = 6'd1;
  localparam logic [5:0] BASE_MID_4  = 6'd8;
  localparam logic [5:0] BASE_MID_16 = 6'd15;
  localparam logic [5:0] BASE_LOW_8  = 6'd22;
  localparam logic [5:0] BASE_LOW_4  = 6'd29;
  localparam logic [5:0] BASE_LOW_16 = 6'd36;
  localparam logic [5:0] BASE_HI_8   = 6'd43;
  localparam logic [5:0] BASE_HI_4   = 6'd50;
  localparam logic [5:0] BASE_HI_16  = 6'd57;

  // Both switches or neither select the middle octave.
  function automatic oct_t oct_of(input logic hi, input logic lo);
    if (hi == lo) return OCT_MID;
    else if (hi)  return OCT_HIGH;
    else          return OCT_LOW;
  endfunction

endpackage

// File: rtl/note_recorder_if.sv
// Song-memory write port: recorder is master, player memory is slave.
// One-cycle strobe with address and 6-bit note code.
interface note_recorder_if;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [5:0]  wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/note_recorder_encoder.sv
// Maps key index, octave and duration class to the 6-bit note code.
// Purely combinational.
module note_code_encoder
  import note_recorder_pkg::*;
(
  input  logic [2:0] key_i,
  input  oct_t       oct_i,
  input  dur_t       dur_i,
  output logic [5:0] code_o
);

  logic [5:0] base;

  // Base code table lookup.
  always_comb begin
    base = BASE_MID_16;
    case ({oct_i, dur_i})
      {OCT_MID,  DUR_8}:  base = BASE_MID_8;
      {OCT_MID,  DUR_4}:  base = BASE_MID_4;
      {OCT_MID,  DUR_16}: base = BASE_MID_16;
      {OCT_LOW,  DUR_8}:  base = BASE_LOW_8;
      {OCT_LOW,  DUR_4}:  base = BASE_LOW_4;
      {OCT_LOW,  DUR_16}: base = BASE_LOW_16;
      {OCT_HIGH, DUR_8}:  base = BASE_HI_8;
      {OCT_HIGH, DUR_4}:  base = BASE_HI_4;
      {OCT_HIGH, DUR_16}: base = BASE_HI_16;
      default:            base = BASE_MID_16;
    endcase
  end

  assign code_o = base + {3'b000, key_i};

endmodule

// File: rtl/note_recorder.sv
// Live key-press recorder: times each press, encodes it and writes
// the code stream (with rests for silences) into song memory.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH     = 16384,
  parameter int MIN_PRESS = 2_000_000,
  parameter int THR_8     = 15_000_000,
  parameter int THR_4     = 30_000_000,
  parameter int REST_LEN  = 25_000_000,
  parameter int MAX_RESTS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rec_en,
  input  logic             clear,
  input  logic [6:0]       note_keys,
  input  logic             is_high,
  input  logic             is_low,
  note_recorder_if.master  mem,
  output logic [14:0]      rec_len,
  output logic             full,
  output logic             recording
);

  localparam int HW = $clog2(THR_4 + 1);
  localparam int SW = $clog2(REST_LEN + 1);
  localparam int RW = $clog2(MAX_RESTS + 1);
  localparam logic [14:0] DEPTH_L = 15'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_PRESS = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [6:0]    k_m_q, k_s_q;
  logic [1:0]    o_m_q, o_s_q;
  logic [2:0]    st_q, st_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [SW-1:0] sil_q, sil_d, sil_inc;
  logic [RW-1:0] rc_q, rc_d;
  logic [2:0]    key_q, key_d;
  oct_t          oct_q, oct_d;
  logic [14:0]   len_q, len_d;
  logic          full_q, full_d;
  logic          we_q, we_d;
  logic [13:0]   addr_q, addr_d;
  logic [5:0]    data_q, data_d;

  logic          k_vld, long_ok, cmt;
  logic [2:0]    k_idx;
  dur_t          dur;
  logic [5:0]    note_code, cmt_code;

  // Two-flop synchronisers for the asynchronous key/switch inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_m_q <= '0;
      k_s_q <= '0;
      o_m_q <= '0;
      o_s_q <= '0;
    end else begin
      k_m_q <= note_keys;
      k_s_q <= k_m_q;
      o_m_q <= {is_high, is_low};
      o_s_q <= o_m_q;
    end
  end

  // One-hot key to index; anything else is treated as no key.
  always_comb begin
    k_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (k_s_q[i]) k_idx = 3'(i);
    end
  end

  assign k_vld = $onehot(k_s_q);

  assign long_ok  = hold_q >= HW'(MIN_PRESS);
  assign hold_inc = (hold_q >= HW'(THR_4)) ? hold_q : hold_q + HW'(1);
  assign sil_inc  = sil_q + SW'(1);
  assign dur = (hold_q >= HW'(THR_4)) ? DUR_4 :
               (hold_q >= HW'(THR_8)) ? DUR_8 : DUR_16;

  note_code_encoder u_enc (
    .key_i  (key_q),
    .oct_i  (oct_q),
    .dur_i  (dur),
    .code_o (note_code)
  );

  // Recording FSM, commit generation, clear override.
  always_comb begin
    st_d     = st_q;
    hold_d   = hold_q;
    sil_d    = sil_q;
    rc_d     = rc_q;
    key_d    = key_q;
    oct_d    = oct_q;
    cmt      = 1'b0;
    cmt_code = note_code;
    if (!rec_en && st_q != S_IDLE) begin
      cmt  = (st_q == S_PRESS) && long_ok;
      st_d = S_DONE;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (rec_en) st_d = S_ARMED;
        end
        S_ARMED: begin
          if (k_vld) begin
            st_d   = S_PRESS;
            hold_d = HW'(1);
            key_d  = k_idx;
            oct_d  = oct_of(o_s_q[1], o_s_q[0]);
          end
        end
        S_PRESS: begin
          if (k_vld && k_idx == key_q) begin
            hold_d = hold_inc;
          end else if (k_vld) begin
            cmt    = long_ok;
            hold_d = HW'(1);
            key_d  = k_idx;
            oct_d  = oct_of(o_s_q[1], o_s_q[0]);
          end else begin
            cmt   = long_ok;
            sil_d = '0;
            st_d  = (long_ok || len_q != '0) ? S_GAP : S_ARMED;
          end
        end
        S_GAP: begin
          if (k_vld) begin
            st_d   = S_PRESS;
            hold_d = HW'(1);
            rc_d   = '0;
            key_d  = k_idx;
            oct_d  = oct_of(o_s_q[1], o_s_q[0]);
          end else if (sil_q < SW'(REST_LEN)) begin
            sil_d = sil_inc;
            if (sil_inc == SW'(REST_LEN) && rc_q < RW'(MAX_RESTS)) begin
              cmt      = 1'b1;
              cmt_code = REST_CODE;
              sil_d    = '0;
              rc_d     = rc_q + RW'(1);
            end
          end
        end
        S_DONE:  st_d = S_DONE;
        default: st_d = S_IDLE;
      endcase
    end

    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    len_d  = len_q;
    full_d = full_q;
    if (cmt && !full_q) begin
      we_d   = 1'b1;
      addr_d = len_q[13:0];
      data_d = cmt_code;
      len_d  = len_q + 15'd1;
      if (len_d == DEPTH_L) begin
        full_d = 1'b1;
        st_d   = S_DONE;
      end
    end

    if (clear) begin
      st_d   = S_IDLE;
      we_d   = 1'b0;
      len_d  = '0;
      full_d = 1'b0;
      hold_d = '0;
      sil_d  = '0;
      rc_d   = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= S_IDLE;
      hold_q <= '0;
      sil_q  <= '0;
      rc_q   <= '0;
      key_q  <= '0;
      oct_q  <= OCT_MID;
      len_q  <= '0;
      full_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      hold_q <= hold_d;
      sil_q  <= sil_d;
      rc_q   <= rc_d;
      key_q  <= key_d;
      oct_q  <= oct_d;
      len_q  <= len_d;
      full_q <= full_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign mem.wr_en   = we_q;
  assign mem.wr_addr = addr_q;
  assign mem.wr_data = data_q;
  assign rec_len     = len_q;
  assign full        = full_q;
  assign recording   = (st_q == S_ARMED) || (st_q == S_PRESS) ||
                       (st_q == S_GAP);

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed and randomized presses checked
// against a code-table model of the recorded stream.
module tb_note_recorder;

  localparam int DEPTH     = 8;
  localparam int MIN_PRESS = 4;
  localparam int THR_8     = 16;
  localparam int THR_4     = 32;
  localparam int REST_LEN  = 40;
  localparam int MAX_RESTS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rec_en = 1'b0;
  logic        clear = 1'b0;
  logic [6:0]  note_keys = '0;
  logic        is_high = 1'b0;
  logic        is_low = 1'b0;
  logic [14:0] rec_len;
  logic        full;
  logic        recording;

  note_recorder_if mem ();

  note_recorder #(
    .DEPTH(DEPTH), .MIN_PRESS(MIN_PRESS), .THR_8(THR_8),
    .THR_4(THR_4), .REST_LEN(REST_LEN), .MAX_RESTS(MAX_RESTS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rec_en    (rec_en),
    .clear     (clear),
    .note_keys (note_keys),
    .is_high   (is_high),
    .is_low    (is_low),
    .mem       (mem),
    .rec_len   (rec_len),
    .full      (full),
    .recording (recording)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];
  int e_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem.wr_en === 1'b1) begin
      wq_addr.push_back(int'(mem.wr_addr));
      wq_data.push_back(int'(mem.wr_data));
      wq_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int exp_code(input int k, input bit hi,
                                  input bit lo, input int n);
    int base;
    int off;
    if (n >= THR_4)      base = 8;
    else if (n >= THR_8) base = 1;
    else                 base = 15;
    if (hi == lo) off = 0;
    else if (hi)  off = 42;
    else          off = 21;
    return base + off + k;
  endfunction

  task automatic press(input int k, input bit hi, input bit lo,
                       input int n);
    note_keys = 7'(1 << k);
    is_high = hi;
    is_low = lo;
    tick(n);
    note_keys = '0;
    is_high = 1'b0;
    is_low = 1'b0;
    if (n >= MIN_PRESS) e_data.push_back(exp_code(k, hi, lo, n));
  endtask

  task automatic start_session;
    rec_en = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    rec_en = 1'b1;
    tick(3);
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    e_data.delete();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(2);
    checks++;
    if (mem.wr_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_wr_en got=%0b want=0", mem.wr_en);
    end
    checks++;
    if (mem.wr_addr !== 14'd0) begin
      failures++;
      $display("FAIL reset_wr_addr got=%0d want=0", mem.wr_addr);
    end
    checks++;
    if (mem.wr_data !== 6'd0) begin
      failures++;
      $display("FAIL reset_wr_data got=%0d want=0", mem.wr_data);
    end
    checks++;
    if (rec_len !== 15'd0 || full !== 1'b0 || recording !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got len=%0d full=%0b rec=%0b want 0/0/0",
               rec_len, full, recording);
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_single;
    start_session();
    press(0, 1'b0, 1'b0, 10);
    tick(6);
    checks++;
    if (wq_data.size() != 1) begin
      failures++;
      $display("FAIL single_count got=%0d want=1", wq_data.size());
    end else begin
      checks++;
      if (wq_addr[0] != 0 || wq_data[0] != 15) begin
        failures++;
        $display("FAIL single_write got addr=%0d data=%0d want 0/15",
                 wq_addr[0], wq_data[0]);
      end
    end
    checks++;
    if (rec_len !== 15'd1 || recording !== 1'b1) begin
      failures++;
      $display("FAIL single_len got len=%0d rec=%0b want 1/1",
               rec_len, recording);
    end
  endtask

  task automatic test_octaves;
    tick(4);
    press(4, 1'b1, 1'b0, 40);
    tick(5);
    press(2, 1'b0, 1'b1, 20);
    tick(6);
    checks++;
    if (wq_data.size() != 3) begin
      failures++;
      $display("FAIL octave_count got=%0d want=3", wq_data.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (wq_addr[i] != i || wq_data[i] != e_data[i]) begin
          failures++;
          $display("FAIL octave_write%0d got addr=%0d data=%0d want %0d/%0d",
                   i, wq_addr[i], wq_data[i], i, e_data[i]);
        end
      end
    end
  endtask

  task automatic test_glitch;
    start_session();
    press(0, 1'b0, 1'b0, 3);
    tick(5);
    note_keys = 7'b0000011;
    tick(20);
    note_keys = '0;
    tick(6);
    checks++;
    if (wq_data.size() != 0 || rec_len !== 15'd0) begin
      failures++;
      $display("FAIL glitch got writes=%0d len=%0d want 0/0",
               wq_data.size(), rec_len);
    end
  endtask

  task automatic test_rests;
    start_session();
    press(0, 1'b0, 1'b0, 10);
    tick(140);
    checks++;
    if (wq_data.size() != 3) begin
      failures++;
      $display("FAIL rest_count got=%0d want=3", wq_data.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (wq_data[i] != 0 || wq_addr[i] != i ||
            wq_cyc[i] - wq_cyc[0] != REST_LEN * i) begin
          failures++;
          $display("FAIL rest%0d got data=%0d addr=%0d dt=%0d want 0/%0d/%0d",
                   i, wq_data[i], wq_addr[i], wq_cyc[i] - wq_cyc[0],
                   i, REST_LEN * i);
        end
      end
    end
  endtask

  task automatic test_boundaries;
    int holds[7];
    holds = '{3, 4, 15, 16, 31, 32, 45};
    start_session();
    for (int i = 0; i < 7; i++) begin
      press(int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom),
            holds[i]);
      tick(5);
    end
    tick(3);
    checks++;
    if (wq_data.size() != e_data.size()) begin
      failures++;
      $display("FAIL bound_count got=%0d want=%0d",
               wq_data.size(), e_data.size());
    end else begin
      for (int i = 0; i < e_data.size(); i++) begin
        checks++;
        if (wq_data[i] != e_data[i] || wq_addr[i] != i) begin
          failures++;
          $display("FAIL bound%0d got addr=%0d data=%0d want %0d/%0d",
                   i, wq_addr[i], wq_data[i], i, e_data[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    start_session();
    note_keys = 7'b0000001;
    tick(10);
    note_keys = 7'b0000010;
    tick(20);
    note_keys = '0;
    tick(6);
    checks++;
    if (wq_data.size() != 2) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=2", wq_data.size());
    end else begin
      checks++;
      if (wq_data[0] != exp_code(0, 0, 0, 10) ||
          wq_data[1] != exp_code(1, 0, 0, 20)) begin
        failures++;
        $display("FAIL b2b_data got=%0d,%0d want=%0d,%0d",
                 wq_data[0], wq_data[1],
                 exp_code(0, 0, 0, 10), exp_code(1, 0, 0, 20));
      end
    end
  endtask

  task automatic test_full;
    start_session();
    for (int i = 0; i < DEPTH; i++) begin
      press(int'($urandom_range(0, 6)), 1'($urandom), 1'($urandom),
            int'($urandom_range(MIN_PRESS, 45)));
      tick(int'($urandom_range(3, 10)));
    end
    tick(4);
    checks++;
    if (wq_data.size() != DEPTH) begin
      failures++;
      $display("FAIL full_count got=%0d want=%0d", wq_data.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (wq_data[i] != e_data[i] || wq_addr[i] != i) begin
          failures++;
          $display("FAIL full_write%0d got addr=%0d data=%0d want %0d/%0d",
                   i, wq_addr[i], wq_data[i], i, e_data[i]);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || recording !== 1'b0 || rec_len !== 15'(DEPTH)) begin
      failures++;
      $display("FAIL full_flag got full=%0b rec=%0b len=%0d want 1/0/%0d",
               full, recording, rec_len, DEPTH);
    end
    press(3, 1'b0, 1'b0, 10);
    tick(6);
    checks++;
    if (wq_data.size() != DEPTH) begin
      failures++;
      $display("FAIL full_ninth got writes=%0d want=%0d",
               wq_data.size(), DEPTH);
    end
    rec_en = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    checks++;
    if (rec_len !== 15'd0 || full !== 1'b0 || recording !== 1'b0) begin
      failures++;
      $display("FAIL full_clear got len=%0d full=%0b rec=%0b want 0/0/0",
               rec_len, full, recording);
    end
  endtask

  task automatic test_reset_mid;
    start_session();
    press(0, 1'b0, 1'b0, 10);
    tick(5);
    note_keys = 7'b0000001;
    tick(20);
    reset = 1'b0;
    #1;
    checks++;
    if (mem.wr_en !== 1'b0 || mem.wr_addr !== 14'd0 ||
        mem.wr_data !== 6'd0 || rec_len !== 15'd0 ||
        full !== 1'b0 || recording !== 1'b0) begin
      failures++;
      $display("FAIL midreset got we=%0b a=%0d d=%0d len=%0d f=%0b r=%0b",
               mem.wr_en, mem.wr_addr, mem.wr_data, rec_len, full,
               recording);
    end
    note_keys = '0;
    tick(3);
    reset = 1'b1;
    tick(20);
    checks++;
    if (wq_data.size() != 1 || rec_len !== 15'd0) begin
      failures++;
      $display("FAIL midreset_after got writes=%0d len=%0d want 1/0",
               wq_data.size(), rec_len);
    end
  endtask

  task automatic test_rec_en_drop;
    start_session();
    note_keys = 7'b0000001;
    tick(10);
    rec_en = 1'b0;
    tick(1);
    note_keys = '0;
    tick(6);
    checks++;
    if (wq_data.size() != 1) begin
      failures++;
      $display("FAIL drop_count got=%0d want=1", wq_data.size());
    end else begin
      checks++;
      if (wq_data[0] != 15 || wq_addr[0] != 0) begin
        failures++;
        $display("FAIL drop_write got addr=%0d data=%0d want 0/15",
                 wq_addr[0], wq_data[0]);
      end
    end
    checks++;
    if (recording !== 1'b0 || rec_len !== 15'd1) begin
      failures++;
      $display("FAIL drop_state got rec=%0b len=%0d want 0/1",
               recording, rec_len);
    end
    rec_en = 1'b1;
    tick(5);
    press(5, 1'b0, 1'b0, 10);
    tick(6);
    checks++;
    if (recording !== 1'b0 || wq_data.size() != 1) begin
      failures++;
      $display("FAIL drop_reenable got rec=%0b writes=%0d want 0/1",
               recording, wq_data.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_octaves();
    test_glitch();
    test_rests();
    test_boundaries();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_rec_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
